// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bus for the pipelined floating-point adder/subtractor.
// Handshake: a beat moves on a channel when its VALID and READY are both high
// at a rising clock edge; the producer holds VALID and data until then.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OP;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] OUT_RES;
    logic [3:0]   OUT_FLAGS;

    // Operand source / result sink side
    modport master (
        output IN_VALID, A, B, OP, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RES, OUT_FLAGS
    );

    // Adder side
    modport slave (
        input  IN_VALID, A, B, OP, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RES, OUT_FLAGS
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: unpack/align, add/sub,
// normalise/round/pack. Subnormal inputs are flushed to signed zero and the
// result is rounded to nearest even. One global enable (advance) moves every
// stage at once, so a stalled output freezes the whole pipe.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           CLK,
    input  logic           RST,
    fp_addsub_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;          // {1, frac, G, R, S}
    localparam int SW   = MAN_W + 5;          // aligned sum with carry
    localparam int EW   = EXP_W + 2;          // exponent with sign and headroom
    localparam int LZ_W = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } spc_t;

    // Leading-zero count of the (non-carry) sum field
    function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && !v[i]) n = n + LZ_W'(1);
            else                 found = 1'b1;
        end
        return n;
    endfunction

    logic advance;

    logic             out_valid_q;
    logic [W-1:0]     out_res_q;
    logic [3:0]       out_flags_q;

    assign advance       = !out_valid_q || bus.OUT_READY;
    assign bus.IN_READY  = advance;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_RES   = out_res_q;
    assign bus.OUT_FLAGS = out_flags_q;

    // ---------------------------------------------------------------- stage 1
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             a_ge_b;

    assign a_sign = bus.A[W-1];
    assign a_exp  = bus.A[W-2:MAN_W];
    assign a_frac = bus.A[MAN_W-1:0];
    assign b_sign = bus.B[W-1] ^ bus.OP;
    assign b_exp  = bus.B[W-2:MAN_W];
    assign b_frac = bus.B[MAN_W-1:0];

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);
    assign a_ge_b = ({a_exp, a_frac} >= {b_exp, b_frac});

    logic             l_sign, s_sign, l_zero, s_zero;
    logic [EXP_W-1:0] l_exp, s_exp, diff;
    logic [MAN_W-1:0] l_frac, s_frac;
    logic [MW-1:0]    l_man, s_man_raw, s_shifted, s_lost, s_man;
    spc_t             spc;
    logic             spc_sign;

    // Swap so L is the larger magnitude, then align S with a sticky bit
    always_comb begin
        l_sign = a_sign; l_exp = a_exp; l_frac = a_frac; l_zero = a_zero;
        s_sign = b_sign; s_exp = b_exp; s_frac = b_frac; s_zero = b_zero;
        if (!a_ge_b) begin
            l_sign = b_sign; l_exp = b_exp; l_frac = b_frac; l_zero = b_zero;
            s_sign = a_sign; s_exp = a_exp; s_frac = a_frac; s_zero = a_zero;
        end
        l_man     = l_zero ? '0 : {1'b1, l_frac, 3'b000};
        s_man_raw = s_zero ? '0 : {1'b1, s_frac, 3'b000};
        diff      = l_exp - s_exp;
        s_shifted = s_man_raw >> diff;
        s_lost    = s_man_raw & ~({MW{1'b1}} << diff);
        if ({2'b00, diff} >= EW'(MAN_W + 3))
            s_man = {{(MW-1){1'b0}}, |s_man_raw};
        else
            s_man = {s_shifted[MW-1:1], s_shifted[0] | (|s_lost)};
    end

    // Special-value classification, highest priority first
    always_comb begin
        spc      = SPC_NONE;
        spc_sign = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            spc = SPC_NAN;
        end else if (a_inf || b_inf) begin
            spc      = SPC_INF;
            spc_sign = a_inf ? a_sign : b_sign;
        end else if (a_zero && b_zero) begin
            spc      = SPC_ZERO;
            spc_sign = a_sign & b_sign;
        end
    end

    logic             s1_valid, s1_sign, s1_sub, s1_spc_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_man_l, s1_man_s;
    spc_t             s1_spc;

    // Stage 1 register: aligned operands and special-case class
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_spc_sign <= 1'b0;
            s1_exp      <= '0;
            s1_man_l    <= '0;
            s1_man_s    <= '0;
            s1_spc      <= SPC_NONE;
        end else if (advance) begin
            s1_valid    <= bus.IN_VALID;
            s1_sign     <= l_sign;
            s1_sub      <= l_sign ^ s_sign;
            s1_spc_sign <= spc_sign;
            s1_exp      <= l_exp;
            s1_man_l    <= l_man;
            s1_man_s    <= s_man;
            s1_spc      <= spc;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic             s2_valid, s2_sign, s2_spc_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;
    spc_t             s2_spc;

    // Stage 2 register: magnitude sum/difference (L >= S so never negative)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_spc_sign <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_spc      <= SPC_NONE;
        end else if (advance) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_spc_sign <= s1_spc_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= s1_sub ? ({1'b0, s1_man_l} - {1'b0, s1_man_s})
                                  : ({1'b0, s1_man_l} + {1'b0, s1_man_s});
            s2_spc      <= s1_spc;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic [LZ_W-1:0]  lz;
    logic [MW-1:0]    m_norm;
    logic [EW-1:0]    e_norm, e_rnd;
    logic             inexact, rnd_up;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac_r;
    logic             uf, of;
    logic [W-1:0]     res;
    logic [3:0]       flags;

    // Normalise, round to nearest even, then resolve specials and range
    always_comb begin
        lz = lzc(s2_sum[MW-1:0]);
        if (s2_sum[SW-1]) begin
            m_norm = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            e_norm = {2'b00, s2_exp} + EW'(1);
        end else begin
            m_norm = s2_sum[MW-1:0] << lz;
            e_norm = {2'b00, s2_exp} - EW'(lz);
        end

        inexact = m_norm[2] | m_norm[1] | m_norm[0];
        rnd_up  = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        mant_r  = {1'b0, m_norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_r[MAN_W+1]) begin
            frac_r = mant_r[MAN_W:1];
            e_rnd  = e_norm + EW'(1);
        end else begin
            frac_r = mant_r[MAN_W-1:0];
            e_rnd  = e_norm;
        end

        of = !e_rnd[EW-1] && (e_rnd[EW-2:0] >= {1'b0, EXP_MAX});
        uf = e_norm[EW-1] || (e_norm == '0);

        res   = '0;
        flags = 4'b0000;
        case (s2_spc)
            SPC_NAN: begin
                res   = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
                flags = 4'b1000;
            end
            SPC_INF:  res = {s2_spc_sign, EXP_MAX, {MAN_W{1'b0}}};
            SPC_ZERO: res = {s2_spc_sign, {(W-1){1'b0}}};
            default: begin
                if (s2_sum == '0) begin
                    res = '0;
                end else if (of) begin
                    res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
                    flags = 4'b0101;
                end else if (uf) begin
                    res   = {s2_sign, {(W-1){1'b0}}};
                    flags = 4'b0011;
                end else begin
                    res   = {s2_sign, e_rnd[EXP_W-1:0], frac_r};
                    flags = {3'b000, inexact};
                end
            end
        endcase
    end

    // Output register: holds result and flags while downstream stalls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            out_res_q   <= res;
            out_flags_q <= flags;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (EXP_W=8, MAN_W=23). Expected {flags, result}
// words come from a table of hand-computed single-precision cases, are
// queued when the DUT accepts the operands and retired when it emits them.
module tb_fp_addsub_pipe;
    localparam int NT = 18;

    logic clk;
    logic rst;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [35:0] exp_q[$];
    int vectors;
    int miscompares;

    // {A, B, OP, expected {NV,OF,UF,NX, result}}
    logic [31:0] t_a  [NT] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40400000,
                               32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
                               32'h7F800000, 32'h7F800000, 32'h00800000, 32'h80000000,
                               32'h00000001, 32'h7FC00001, 32'h40000000, 32'h3F800000,
                               32'hFF800000, 32'h7F800000};
    logic [31:0] t_b  [NT] = '{32'h3F800000, 32'hBF000000, 32'h3F800000, 32'h3F800000,
                               32'h33800000, 32'h33800001, 32'h33800000, 32'h7F7FFFFF,
                               32'hFF800000, 32'h3F800000, 32'h00800001, 32'h80000000,
                               32'h80000000, 32'h3F800000, 32'h40400000, 32'h2F800000,
                               32'h3F800000, 32'h7F800000};
    logic        t_op [NT] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [35:0] t_e  [NT] = '{{4'h0, 32'h40000000}, {4'h0, 32'h3F800000},
                               {4'h0, 32'h00000000}, {4'h0, 32'h40000000},
                               {4'h1, 32'h3F800000}, {4'h1, 32'h3F800001},
                               {4'h1, 32'h3F800002}, {4'h5, 32'h7F800000},
                               {4'h8, 32'h7FC00000}, {4'h0, 32'h7F800000},
                               {4'h3, 32'h80000000}, {4'h0, 32'h80000000},
                               {4'h0, 32'h00000000}, {4'h8, 32'h7FC00000},
                               {4'h0, 32'hBF800000}, {4'h1, 32'h3F800000},
                               {4'h0, 32'hFF800000}, {4'h8, 32'h7FC00000}};

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    // Scoreboard: retire each delivered result against the queue head
    always @(negedge clk) begin
        if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_output: got %h, expected no output",
                       {bus.OUT_FLAGS, bus.OUT_RES});
            end
            if (exp_q.size() != 0)
                chk("result", {bus.OUT_FLAGS, bus.OUT_RES}, exp_q.pop_front());
        end
    end

    // Present table entry idx and hold it until accepted; returns #1 after the accept edge
    task automatic send(input int idx);
        logic rdy;
        int   n;
        bus.IN_VALID = 1'b1;
        bus.A        = t_a[idx];
        bus.B        = t_b[idx];
        bus.OP       = t_op[idx];
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.IN_READY;
            @(posedge clk);
            #1;
            n++;
        end
        if (rdy) exp_q.push_back(t_e[idx]);
        vectors++;
        assert (rdy) else begin
            miscompares++;
            $error("FAIL accept_timeout: got no accept after %0d cycles, expected accept", n);
        end
    endtask

    // Issue one op into an idle pipe and count rising edges until OUT_VALID
    task automatic lat_check(input int idx, input string tag);
        int n;
        bus.IN_VALID = 1'b1;
        bus.A        = t_a[idx];
        bus.B        = t_b[idx];
        bus.OP       = t_op[idx];
        exp_q.push_back(t_e[idx]);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (bus.OUT_VALID) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 36'(n), 36'd3);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(tag, 36'(exp_q.size()), 36'd0);
    endtask

    // Directed sequence
    initial begin
        int start;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.OP       = 1'b0;
        bus.OUT_READY = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 36'(bus.OUT_VALID), 36'd0);
        chk("rst_out_res",   36'(bus.OUT_RES),   36'd0);
        chk("rst_out_flags", 36'(bus.OUT_FLAGS), 36'd0);
        chk("rst_in_ready",  36'(bus.IN_READY),  36'd1);

        // 1.0 + 1.0 with latency measurement, then every table case back-to-back
        lat_check(0, "latency_first");
        wait_drain("drain_first");
        for (int i = 1; i < NT; i++) send(i);
        bus.IN_VALID = 1'b0;
        wait_drain("drain_directed");

        // Backpressure: 8 back-to-back ops, OUT_READY low 5 cycles from first OUT_VALID
        start = $urandom_range(0, NT - 1);
        fork
            begin
                for (int i = 0; i < 8; i++) send((start + i) % NT);
                bus.IN_VALID = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (n < 30) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (bus.OUT_VALID) break;
                end
                chk("bp_out_valid_seen", 36'(bus.OUT_VALID), 36'd1);
                bus.OUT_READY = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 36'(bus.IN_READY), 36'd0);
                    if (exp_q.size() != 0)
                        chk("stall_hold", {bus.OUT_FLAGS, bus.OUT_RES}, exp_q[0]);
                    @(posedge clk);
                    #1;
                end
                bus.OUT_READY = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // Reset mid-flight: three ops accepted, reset pulsed between edges
        send(0);
        send(1);
        send(3);
        bus.IN_VALID = 1'b0;
        chk("pre_rst_out_valid", 36'(bus.OUT_VALID), 36'd1);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", 36'(bus.OUT_VALID), 36'd0);
        chk("async_rst_out_res",   36'(bus.OUT_RES),   36'd0);
        chk("async_rst_out_flags", 36'(bus.OUT_FLAGS), 36'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 36'(bus.IN_READY), 36'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 36'(bus.OUT_VALID), 36'd0);
        end
        @(posedge clk);
        #1;
        lat_check(5, "latency_after_reset");
        wait_drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
